lcd_hd44780_ctrl: RTL and testbench

HD44780-compatible character-LCD controller in 8-bit parallel mode, sitting between the scheduling core and the board LCD header. After reset it runs the power-up initialisation sequence autonomously. It then accepts one command or character byte at a time over a valid/ready handshake and generates the RS/E/DB timing on `lcd_data`, `lcd_rs` and `lcd_en`. It runs on the fast board clock, so the core never has to meet LCD bus timing itself.

---
 rtl/lcd_hd44780_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit parallel LCD controller: autonomous power-up init, then one
// command/character byte per valid/ready handshake with RS/E/DB bus timing.
module lcd_hd44780_ctrl #(
  parameter int unsigned POWERUP_CYC   = 2_000_000,
  parameter int unsigned EN_HIGH_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC  = 2_500,
  parameter int unsigned LONG_WAIT_CYC = 250_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_byte_i,
  output logic       cmd_ready_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o
);

  // A zero-length phase still occupies one cycle.
  localparam int unsigned PWR_N  = (POWERUP_CYC   == 0) ? 1 : POWERUP_CYC;
  localparam int unsigned EN_N   = (EN_HIGH_CYC   == 0) ? 1 : EN_HIGH_CYC;
  localparam int unsigned CMD_N  = (CMD_WAIT_CYC  == 0) ? 1 : CMD_WAIT_CYC;
  localparam int unsigned LONG_N = (LONG_WAIT_CYC == 0) ? 1 : LONG_WAIT_CYC;
  localparam int unsigned MAX_A  = (PWR_N > EN_N)   ? PWR_N : EN_N;
  localparam int unsigned MAX_B  = (CMD_N > LONG_N) ? CMD_N : LONG_N;
  localparam int unsigned MAX_N  = (MAX_A > MAX_B)  ? MAX_A : MAX_B;
  localparam int          CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_N - 1);
  localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(EN_N - 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_N - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_N - 1);
  localparam logic [2:0]       INIT_LAST = 3'd5;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_EN_HIGH,
    S_WAIT,
    S_IDLE
  } state_e;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;  // function set: 8-bit, 2 lines
      3'd3:             init_byte = 8'h0C;  // display on, cursor off
      3'd4:             init_byte = 8'h01;  // clear
      default:          init_byte = 8'h06;  // entry mode: increment
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             long_q, long_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] wait_last;
  logic [2:0]       idx_next;

  assign wait_last = long_q ? LONG_LAST : CMD_LAST;
  assign idx_next  = idx_q + 3'd1;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;
    done_d  = done_q;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = '0;
          state_d = S_SETUP;
          idx_d   = 3'd0;
          data_d  = init_byte(3'd0);
          rs_d    = 1'b0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_EN_HIGH;
      end
      S_EN_HIGH: begin
        if (cnt_q == EN_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (!done_q && idx_q != INIT_LAST) begin
            state_d = S_SETUP;
            idx_d   = idx_next;
            data_d  = init_byte(idx_next);
            rs_d    = 1'b0;
            long_d  = (init_byte(idx_next) == 8'h01);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_SETUP;
          data_d  = cmd_byte_i;
          rs_d    = cmd_rs_i;
          long_d  = !cmd_rs_i && (cmd_byte_i == 8'h01 || cmd_byte_i == 8'h02);
        end
      end
      default: state_d = S_PWRUP;
    endcase

    // Strobe and ready are registered from the next state to stay glitch-free.
    en_d    = (state_d == S_EN_HIGH);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      done_q  <= done_d;
      en_q    <= en_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign init_done_o = done_q;
  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_en_o    = en_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl: init sequence, handshake latency,
// wait-length rules, back-to-back transfers and reset recovery.
module tb_lcd_hd44780_ctrl;

  localparam int P_PWR  = 20;
  localparam int P_EN   = 3;
  localparam int P_CMD  = 5;
  localparam int P_LONG = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_ready, init_done, lcd_rs, lcd_en;
  logic [7:0] lcd_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  lcd_hd44780_ctrl #(
    .POWERUP_CYC(P_PWR), .EN_HIGH_CYC(P_EN),
    .CMD_WAIT_CYC(P_CMD), .LONG_WAIT_CYC(P_LONG)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_rs_i(cmd_rs),
    .cmd_byte_i(cmd_byte), .cmd_ready_o(cmd_ready), .init_done_o(init_done),
    .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_en_o(lcd_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0] init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int user_wait(input logic rs, input logic [7:0] b);
    return (!rs && (b == 8'h01 || b == 8'h02)) ? P_LONG : P_CMD;
  endfunction

  function automatic int user_latency(input logic rs, input logic [7:0] b);
    return 1 + P_EN + user_wait(rs, b) + 1;
  endfunction

  function automatic int init_length();
    int total = P_PWR;
    for (int i = 0; i < 6; i++)
      total += 1 + P_EN + ((i == 0 || init_seq[i] == 8'h01) ? P_LONG : P_CMD);
    return total;
  endfunction

  // ---------------- bus pulse monitor ----------------
  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         width;
    bit         setup_ok;
    bit         stable_ok;
  } pulse_t;

  pulse_t     pulses[$];
  pulse_t     cur;
  bit         in_pulse = 0;
  logic       en_p = 1'b0;
  logic [7:0] d_p = 8'h00;
  logic       rs_p = 1'b0;

  always @(negedge clk) begin
    if (lcd_en && !en_p) begin
      cur.data = lcd_data; cur.rs = lcd_rs; cur.width = 1;
      cur.setup_ok = (d_p === lcd_data) && (rs_p === lcd_rs);
      cur.stable_ok = 1; in_pulse = 1;
    end else if (lcd_en && in_pulse) begin
      cur.width++;
      if (lcd_data !== cur.data || lcd_rs !== cur.rs) cur.stable_ok = 0;
    end else if (!lcd_en && in_pulse) begin
      pulses.push_back(cur);
      in_pulse = 0;
    end
    en_p = lcd_en; d_p = lcd_data; rs_p = lcd_rs;
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic measure_init(output int lat, output bit together);
    lat = 0; together = 1;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (cmd_ready !== init_done) together = 0;
      if (init_done === 1'b1) begin lat = n; return; end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (cmd_ready === 1'b1) begin ok = 1; return; end
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns accept-to-ready latency in clocks.
  task automatic send_byte(input logic rs, input logic [7:0] b, output int lat);
    bit ok;
    int acc;
    lat = -1;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_rs = rs; cmd_byte = b;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin lat = cyc + 1 - acc; return; end
    end
  endtask

  task automatic check_pulse(input string name, input int i, input logic rs, input logic [7:0] b);
    tests++;
    if (i >= pulses.size()) begin
      fails++; $display("FAIL %s: pulse %0d missing (got %0d pulses)", name, i, pulses.size());
      return;
    end
    if (pulses[i].data !== b || pulses[i].rs !== rs || pulses[i].width != P_EN ||
        !pulses[i].setup_ok || !pulses[i].stable_ok) begin
      fails++;
      $display("FAIL %s: pulse %0d got data=%h rs=%b width=%0d setup=%0d stable=%0d, want data=%h rs=%b width=%0d setup=1 stable=1",
               name, i, pulses[i].data, pulses[i].rs, pulses[i].width, pulses[i].setup_ok,
               pulses[i].stable_ok, b, rs, P_EN);
    end
  endtask

  task automatic check_init_run(input string name);
    int lat; bit tog;
    measure_init(lat, tog);
    tests++;
    if (lat != init_length()) begin
      fails++; $display("FAIL %s_len: got %0d clocks, want %0d", name, lat, init_length());
    end
    tests++;
    if (!tog || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s_ready_with_done: together=%0d ready=%b, want 1/1", name, tog, cmd_ready);
    end
    tests++;
    if (pulses.size() != 6) begin
      fails++; $display("FAIL %s_pulse_count: got %0d, want 6", name, pulses.size());
    end
    for (int i = 0; i < 6; i++) check_pulse(name, i, 1'b0, init_seq[i]);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({lcd_data, lcd_rs, lcd_en, cmd_ready, init_done} !== 12'h000) begin
      fails++;
      $display("FAIL reset_values: data=%h rs=%b en=%b ready=%b done=%b, want all 0",
               lcd_data, lcd_rs, lcd_en, cmd_ready, init_done);
    end
  endtask

  task automatic test_init();
    pulses.delete();
    rst = 1'b0;
    check_init_run("init");
  endtask

  task automatic test_single_data();
    int lat;
    pulses.delete();
    send_byte(1'b1, 8'h41, lat);
    tests++;
    if (lat != user_latency(1'b1, 8'h41)) begin
      fails++; $display("FAIL data41_latency: got %0d, want %0d", lat, user_latency(1'b1, 8'h41));
    end
    check_pulse("data41", 0, 1'b1, 8'h41);
  endtask

  task automatic test_wait_rules();
    int lat;
    logic [7:0] b;
    logic rs;
    for (int k = 0; k < 26; k++) begin
      if (k == 0)      begin rs = 1'b0; b = 8'h01; end
      else if (k == 1) begin rs = 1'b0; b = 8'h80; end
      else begin
        rs = 1'($urandom_range(0, 1));
        b  = 8'($urandom);
        if ($urandom_range(0, 2) == 0) b = 8'($urandom_range(1, 2));
      end
      pulses.delete();
      send_byte(rs, b, lat);
      tests++;
      if (lat != user_latency(rs, b)) begin
        fails++;
        $display("FAIL wait_rule[%0d] rs=%b byte=%h: latency %0d, want %0d",
                 k, rs, b, lat, user_latency(rs, b));
      end
      check_pulse("wait_rule", 0, rs, b);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, early;
    bit ok, seen;
    pulses.delete();
    early = 0; seen = 0;
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_byte = 8'h48;
    @(posedge clk); #1;
    acc1 = cyc;
    cmd_byte = 8'h49;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (lcd_data !== 8'h48) early++;
      if (cmd_ready === 1'b1) begin seen = 1; break; end
    end
    @(posedge clk); #1;
    acc2 = cyc;
    cmd_valid = 1'b0;
    tests++;
    if (!seen || acc2 - acc1 != user_latency(1'b1, 8'h48)) begin
      fails++; $display("FAIL b2b_spacing: got %0d, want %0d", acc2 - acc1, user_latency(1'b1, 8'h48));
    end
    tests++;
    if (early != 0) begin
      fails++; $display("FAIL b2b_early_data: %0d cycles off 0x48 before second setup, want 0", early);
    end
    @(negedge clk);
    tests++;
    if (lcd_data !== 8'h49 || lcd_en !== 1'b0) begin
      fails++; $display("FAIL b2b_setup: data=%h en=%b, want 49/0", lcd_data, lcd_en);
    end
    wait_ready(ok);
    tests++;
    if (!ok || pulses.size() != 2) begin
      fails++; $display("FAIL b2b_pulse_count: got %0d (ready=%0d), want 2", pulses.size(), ok);
    end
    check_pulse("b2b", 0, 1'b1, 8'h48);
    check_pulse("b2b", 1, 1'b1, 8'h49);
  endtask

  task automatic test_valid_during_init();
    int n; bit early, ok;
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_byte = 8'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pulses.delete();
    rst = 1'b0;
    early = 0; n = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1 && init_done !== 1'b1) early = 1;
      if (cmd_ready === 1'b1) begin n = k; break; end
    end
    tests++;
    if (early || n != init_length()) begin
      fails++; $display("FAIL vinit_first_ready: at clock %0d early=%0d, want %0d early=0", n, early, init_length());
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests++;
    if (cmd_ready !== 1'b0 || lcd_data !== 8'h55 || lcd_rs !== 1'b1) begin
      fails++; $display("FAIL vinit_accept: ready=%b data=%h rs=%b, want 0/55/1", cmd_ready, lcd_data, lcd_rs);
    end
    wait_ready(ok);
    tests++;
    if (!ok || pulses.size() != 7) begin
      fails++; $display("FAIL vinit_pulse_count: got %0d, want 7", pulses.size());
    end
    check_pulse("vinit", 6, 1'b1, 8'h55);
  endtask

  task automatic test_reset_mid_pulse();
    bit ok, hit;
    hit = 0;
    wait_ready(ok);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_byte = 8'h5A;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (lcd_en === 1'b1) begin hit = 1; break; end
    end
    @(negedge clk);
    tests++;
    if (!hit || lcd_en !== 1'b1) begin
      fails++; $display("FAIL rst_mid_pulse_en: en=%b seen=%0d, want 1 in 2nd cycle", lcd_en, hit);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (lcd_en !== 1'b0 || cmd_ready !== 1'b0 || init_done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_pulse_clear: en=%b ready=%b done=%b, want 0/0/0",
                        lcd_en, cmd_ready, init_done);
    end
    repeat (2) @(negedge clk);
    pulses.delete();
    rst = 1'b0;
    check_init_run("reinit");
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_data();
    test_wait_rules();
    test_back_to_back();
    test_valid_during_init();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

endmodule
